// File: rtl/mem_arb_pkg.sv
// Shared types for the unified I/D memory arbiter: FSM states and request owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/unified_mem_arbiter_arb_pick.sv
// Combinational winner select between fetch and data ports.
// ARB_ROUND_ROBIN_EN defined: contention alternates against rr_last; undefined: D always wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t rr_last,
    output owner_t winner,
    output logic   any
);

    assign any = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        if (i_req && d_req) begin
            winner = (rr_last == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end else begin
            winner = OWN_I;
        end
    end
`else
    // Fixed priority has no use for the last-granted history.
    owner_t unused_rr_last;
    assign unused_rr_last = rr_last;
    assign winner         = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and load/store (D) ports,
// with at most one read outstanding. Optional round-robin contention via ARB_ROUND_ROBIN_EN.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            proto_err
);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     rr_last_q, rr_last_d;
    logic       proto_err_q, proto_err_d;

    owner_t winner;
    logic   any;
    owner_t sel;
    logic   issue;
    logic   accept;
    logic   sel_read;
    logic   resp;

    arb_pick u_arb_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .rr_last (rr_last_q),
        .winner  (winner),
        .any     (any)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        proto_err_d = proto_err_q | (mem_rvalid && (state_q != ST_RESP));
        sel         = owner_q;
        issue       = 1'b0;

        // Holding reset low silences every output, whatever the inputs do.
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        sel     = winner;
                        issue   = 1'b1;
                        owner_d = winner;
                    end
                end
                ST_HOLD: begin
                    issue = 1'b1;
                end
                ST_RESP: ;
                default: state_d = ST_IDLE;
            endcase
        end

        sel_read = (sel == OWN_I) || !d_we;
        accept   = issue && mem_ready;
        resp     = reset && (state_q == ST_RESP) && mem_rvalid;

        if (issue) begin
            state_d = accept ? (sel_read ? ST_RESP : ST_IDLE) : ST_HOLD;
        end
        if (accept) begin
            rr_last_d = sel;
        end
        if (resp) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        mem_req   = issue;
        mem_we    = issue && (sel == OWN_D) && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (issue) begin
            mem_addr  = (sel == OWN_D) ? d_addr : i_addr;
            mem_wdata = (sel == OWN_D) ? d_wdata : '0;
            mem_be    = ((sel == OWN_D) && d_we) ? d_be : '1;
        end

        i_gnt    = accept && (sel == OWN_I);
        d_gnt    = accept && (sel == OWN_D);
        i_rvalid = resp && (owner_q == OWN_I);
        d_rvalid = resp && (owner_q == OWN_D);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

    assign proto_err = proto_err_q;

    // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_D;
            rr_last_q   <= OWN_I;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and random stimulus for unified_mem_arbiter against a transaction-level model.
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          proto_err;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .proto_err  (proto_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: port numbers 0 = I, 1 = D, -1 = nobody.
    int m_wait;   // port whose read response is still owed
    int m_lock;   // port whose request memory has not yet accepted
    int m_last;   // port granted most recently
    bit m_err;
    bit exp_i_gnt, exp_d_gnt;
    bit i_pending, d_pending;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        int            port;
        bit            store;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_ird, e_drd;
        logic [BW-1:0] e_be;
        bit            e_irv, e_drv;

        @(negedge clk);
        port    = -1;
        store   = 1'b0;
        e_addr  = '0;
        e_wdata = '0;
        e_be    = '0;
        e_irv   = 1'b0;
        e_drv   = 1'b0;
        e_ird   = '0;
        e_drd   = '0;

        if (reset) begin
            if (m_wait < 0) begin
                if (m_lock >= 0)          port = m_lock;
                else if (i_req && d_req)  port = RR ? ((m_last == 1) ? 0 : 1) : 1;
                else if (d_req)           port = 1;
                else if (i_req)           port = 0;
            end
            if (port == 1) begin
                store   = d_we;
                e_addr  = d_addr;
                e_wdata = d_wdata;
                e_be    = d_we ? d_be : '1;
            end else if (port == 0) begin
                e_addr = i_addr;
                e_be   = '1;
            end
            if (m_wait == 0 && mem_rvalid) begin
                e_irv = 1'b1;
                e_ird = mem_rdata;
            end
            if (m_wait == 1 && mem_rvalid) begin
                e_drv = 1'b1;
                e_drd = mem_rdata;
            end
        end
        exp_i_gnt = (port == 0) && mem_ready;
        exp_d_gnt = (port == 1) && mem_ready;

        check({tag, ".mem_req"},   mem_req,   port >= 0);
        check({tag, ".mem_we"},    mem_we,    store);
        check({tag, ".mem_addr"},  mem_addr,  e_addr);
        check({tag, ".mem_wdata"}, mem_wdata, e_wdata);
        check({tag, ".mem_be"},    mem_be,    e_be);
        check({tag, ".i_gnt"},     i_gnt,     exp_i_gnt);
        check({tag, ".d_gnt"},     d_gnt,     exp_d_gnt);
        check({tag, ".i_rvalid"},  i_rvalid,  e_irv);
        check({tag, ".i_rdata"},   i_rdata,   e_ird);
        check({tag, ".d_rvalid"},  d_rvalid,  e_drv);
        check({tag, ".d_rdata"},   d_rdata,   e_drd);
        check({tag, ".proto_err"}, proto_err, m_err);

        if (!reset) begin
            m_wait = -1;
            m_lock = -1;
            m_last = 0;
            m_err  = 1'b0;
        end else begin
            if (mem_rvalid && m_wait < 0)  m_err = 1'b1;
            if (mem_rvalid && m_wait >= 0) m_wait = -1;
            if (port >= 0) begin
                if (mem_ready) begin
                    m_lock = -1;
                    m_last = port;
                    if (!store) m_wait = port;
                end else begin
                    m_lock = port;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    initial begin
        m_wait = -1;
        m_lock = -1;
        m_last = 0;
        m_err  = 1'b0;
        reset  = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;

        // 1: reset held with random inputs
        for (int k = 0; k < 4; k++) begin
            i_req = 1'($urandom); i_addr = $urandom; d_req = 1'($urandom); d_we = 1'($urandom);
            d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
            mem_ready = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            step("t1_reset");
        end
        reset = 1'b1;
        idle_inputs();
        step("t1_idle");

        // 2: single fetch, one-cycle memory
        i_req = 1'b1; i_addr = 32'h100; mem_ready = 1'b1;
        step("t2_gnt");
        i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        step("t2_rvalid");
        mem_rvalid = 1'b0;
        step("t2_after");

        // 3: simultaneous fetch and load, then sustained contention
        i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        step("t3_both");
        d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step("t3_dresp");
        mem_rvalid = 1'b0;
        step("t3_igrant");
        i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
        step("t3_iresp");
        mem_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h3000;
        for (int k = 0; k < 10; k++) begin
            mem_rvalid = (m_wait >= 0);
            mem_rdata  = 32'hA000_0000 + 32'(k);
            step("t3_contend");
        end
        i_req = 1'b0; d_req = 1'b0;
        mem_rvalid = (m_wait >= 0);
        step("t3_drain");
        mem_rvalid = 1'b0;
        step("t3_quiet");

        // 4: store stalled by memory while fetch waits
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
        mem_ready = 1'b0;
        step("t4_stall0");
        i_req = 1'b1; i_addr = 32'h108;
        step("t4_stall1");
        step("t4_stall2");
        mem_ready = 1'b1;
        step("t4_dgnt");
        d_req = 1'b0; d_we = 1'b0;
        step("t4_iissue");
        i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_6666;
        step("t4_iresp");
        mem_rvalid = 1'b0;

        // 5: stray response in IDLE
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_8888;
        step("t5_stray");
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) step("t5_sticky");
        reset = 1'b0;
        step("t5_reset");
        reset = 1'b1;
        step("t5_clear");

        // 6: reset abandons an outstanding fetch
        i_req = 1'b1; i_addr = 32'h10C; mem_ready = 1'b1;
        step("t6_gnt");
        i_req = 1'b0; reset = 1'b0;
        step("t6_reset");
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step("t6_late");
        mem_rvalid = 1'b0;
        step("t6_err");
        reset = 1'b0;
        step("t6_reset2");
        reset = 1'b1;

        // Random traffic: ports hold requests until granted, memory answers reads at random
        i_pending = 1'b0;
        d_pending = 1'b0;
        idle_inputs();
        for (int k = 0; k < 300; k++) begin
            if (!i_pending) begin
                i_req = ($urandom_range(0, 2) != 0);
                if (i_req) begin
                    i_addr    = $urandom & 32'hFFFF_FFFC;
                    i_pending = 1'b1;
                end
            end
            if (!d_pending) begin
                d_req = ($urandom_range(0, 2) != 0);
                if (d_req) begin
                    d_we      = 1'($urandom);
                    d_addr    = $urandom;
                    d_wdata   = $urandom;
                    d_be      = 4'($urandom);
                    d_pending = 1'b1;
                end
            end
            mem_ready  = ($urandom_range(0, 3) != 0);
            mem_rvalid = (m_wait >= 0) && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            step("rnd");
            if (exp_i_gnt) i_pending = 1'b0;
            if (exp_d_gnt) d_pending = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
